// File: rtl/picosoc_iomem_pkg.sv
// Shared constants, FSM state type and byte-strobe helper for iomem responders.
package picosoc_iomem_pkg;

    localparam int WIN_BITS = 8;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_LOAD     = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_PRESCALE = 8'h10;
    localparam logic [7:0] OFF_CAPTURE  = 8'h14;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CTRL_IRQ = 2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} resp_state_e;

    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/picosoc_iomem_resp.sv
// Reusable iomem responder: turns a held select into a one-cycle ready after
// WAIT_STATES extra cycles; commit_o marks the cycle a write takes effect.
module picosoc_iomem_resp
    import picosoc_iomem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_i,
    output logic       ready_o,
    output logic       commit_o,
    output logic [2:0] wait_cnt_o
);

    resp_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel_i) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                // initiator withdrew the request early: abandon silently
                if (!sel_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 3'd1) begin
                    state_d = ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready_o    = (state_q == ACK);
    assign commit_o   = (state_q == ACK);
    assign wait_cnt_o = cnt_q;

endmodule

// File: rtl/picosoc_iomem_timer.sv
// Memory-mapped prescaled down-counter timer on the iomem bus with sticky expiry and irq.
// Optional capture register at 0x14 is built only when IOMEM_TIMER_CAPTURE_EN is defined.
module picosoc_iomem_timer
    import picosoc_iomem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    input  logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_rdata,
    input  logic        capture_in,
    output logic        irq
);

    logic        sel, ack, wr;
    logic [2:0]  wait_cnt;
    logic [7:0]  off;
    logic        wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
    logic [31:0] cap_rd;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        irq_q;
    logic        tick;

    assign sel = iomem_valid && (iomem_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign off = {iomem_addr[WIN_BITS-1:2], 2'b00};

    picosoc_iomem_resp #(.WAIT_STATES(WAIT_STATES)) u_resp (
        .clk        (clk),
        .reset      (reset),
        .sel_i      (sel),
        .ready_o    (iomem_ready),
        .commit_o   (ack),
        .wait_cnt_o (wait_cnt)
    );

    assign wr        = ack && (iomem_wstrb != 4'd0);
    assign wr_ctrl   = wr && (off == OFF_CTRL);
    assign wr_load   = wr && (off == OFF_LOAD);
    assign wr_count  = wr && (off == OFF_COUNT);
    assign wr_status = wr && (off == OFF_STATUS);
    assign wr_presc  = wr && (off == OFF_PRESCALE);

    assign tick = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            irq_q     <= expired_q && ctrl_q[CTRL_IRQ];
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;

        if (!ctrl_q[CTRL_EN] || tick) pcnt_d = '0;
        else                          pcnt_d = pcnt_q + 16'd1;

        // a bus write to COUNT swallows a coincident tick entirely
        if (tick && !wr_count) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (ctrl_q[CTRL_AR]) count_d = load_q;
                else                 ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        if (wr_ctrl && iomem_wstrb[0]) ctrl_d  = iomem_wdata[2:0];
        if (wr_load)                   load_d  = wstrb_merge(load_q, iomem_wdata, iomem_wstrb);
        if (wr_count)                  count_d = wstrb_merge(count_q, iomem_wdata, iomem_wstrb);
        if (wr_presc) begin
            if (iomem_wstrb[0]) presc_d[7:0]  = iomem_wdata[7:0];
            if (iomem_wstrb[1]) presc_d[15:8] = iomem_wdata[15:8];
        end
        // W1C loses to an expiry landing in the same cycle
        if (wr_status && iomem_wstrb[0] && iomem_wdata[0] && !(tick && !wr_count && count_q == 32'd0))
            expired_d = 1'b0;
    end

    assign irq = irq_q;

`ifdef IOMEM_TIMER_CAPTURE_EN
    logic [2:0]  cap_sync_q;
    logic [31:0] capture_q;
    logic        unused_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_sync_q <= '0;
            capture_q  <= '0;
        end else begin
            cap_sync_q <= {cap_sync_q[1:0], capture_in};
            if (cap_sync_q[1] && !cap_sync_q[2]) capture_q <= count_q;
        end
    end

    assign cap_rd    = capture_q;
    assign unused_ok = ^{iomem_addr[1:0], wait_cnt};
`else
    logic unused_ok;
    assign cap_rd    = '0;
    assign unused_ok = ^{iomem_addr[1:0], wait_cnt, capture_in};
`endif

    always_comb begin
        iomem_rdata = '0;
        if (iomem_ready) begin
            case (off)
                OFF_CTRL:     iomem_rdata = {29'd0, ctrl_q};
                OFF_LOAD:     iomem_rdata = load_q;
                OFF_COUNT:    iomem_rdata = count_q;
                OFF_STATUS:   iomem_rdata = {31'd0, expired_q};
                OFF_PRESCALE: iomem_rdata = {16'd0, presc_q};
                OFF_CAPTURE:  iomem_rdata = cap_rd;
                default:      iomem_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// Bench: two timer instances OR-combined on one iomem bus (0 and 3 wait states).
module tb_picosoc_iomem_timer;

    localparam logic [31:0] B0 = 32'h0300_0000;
    localparam logic [31:0] B1 = 32'h0300_0100;
    localparam logic [31:0] R_CTRL = 32'h00, R_LOAD = 32'h04, R_COUNT = 32'h08;
    localparam logic [31:0] R_STAT = 32'h0C, R_PRE = 32'h10, R_CAP = 32'h14;

    logic        clk = 1'b0, reset = 1'b1, valid = 1'b0, cap = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        r0, r1, irq0, irq1;
    logic [31:0] d0, d1;
    wire         ready = r0 | r1;
    wire  [31:0] rdata = d0 | d1;

    int          n_chk = 0, n_fail = 0;
    int unsigned cyc = 0, last_ack = 0;
    logic [2:0]  e_ctrl = '0;
    logic [31:0] e_load = '0, e_count = '0, e_pre = '0;

    picosoc_iomem_timer #(.BASE_ADDR(B0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .iomem_valid(valid), .iomem_ready(r0),
        .iomem_addr(addr), .iomem_wdata(wdata), .iomem_wstrb(wstrb),
        .iomem_rdata(d0), .capture_in(cap), .irq(irq0));
    picosoc_iomem_timer #(.BASE_ADDR(B1), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset), .iomem_valid(valid), .iomem_ready(r1),
        .iomem_addr(addr), .iomem_wdata(wdata), .iomem_wstrb(wstrb),
        .iomem_rdata(d1), .capture_in(1'b0), .irq(irq1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Runs one transfer; returns the cycle after the acknowledge with valid dropped.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat);
        addr = a; wdata = d; wstrb = s; valid = 1'b1; lat = 0; rd = '0;
        forever begin
            @(posedge clk); #1; lat++;
            if (ready) begin rd = rdata; last_ack = cyc; break; end
            if (lat >= 20) begin
                n_chk++; n_fail++;
                $display("FAIL xfer_timeout addr=%h: no ready after %0d cycles, required ready", a, lat);
                break;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0; wstrb = '0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_chk++;
        if ({r0, r1, irq0, irq1} !== 4'b0 || d0 !== 32'd0 || d1 !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs: got r=%b%b irq=%b%b rd=%h/%h, required all 0", r0, r1, irq0, irq1, d0, d1);
        end
        for (int i = 0; i < 6; i++) begin
            xfer(B0 + 32'(4*i), 32'd0, 4'd0, rd, lat);
            n_chk++;
            if (rd !== 32'd0 || lat !== 1) begin
                n_fail++; $display("FAIL reset_reg off=%0h: got %h lat %0d, required 0 lat 1", 4*i, rd, lat);
            end
        end
        n_chk++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_one_cycle: got %b, required 0", ready); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd; int lat; bit seen;
        seen = 0;
        addr = B1 + R_LOAD; wdata = 32'h1234; wstrb = 4'hF; valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; seen |= ready; end
        reset = 1'b1; valid = 1'b0; wstrb = '0;
        @(posedge clk); #1; seen |= ready;
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; seen |= ready; end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL mid_reset_ready: got ready 1, required 0"); end
        xfer(B1 + R_LOAD, 32'd0, 4'd0, rd, lat);
        n_chk++;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL mid_reset_load: got %h, required 0", rd); end
    endtask

    task automatic test_wstrb();
        logic [31:0] rd; int lat;
        xfer(B1 + R_LOAD, 32'h0000_0010, 4'b0011, rd, lat);
        e_load = bmerge(e_load, 32'h0000_0010, 4'b0011);
        n_chk++;
        if (lat !== 4) begin n_fail++; $display("FAIL ws3_latency: got %0d, required 4", lat); end
        xfer(B1 + R_LOAD, 32'd0, 4'd0, rd, lat);
        n_chk++;
        if (rd !== 32'h0000_0010) begin n_fail++; $display("FAIL load_lo: got %h, required 00000010", rd); end
        xfer(B1 + R_LOAD, 32'hAABB_CCDD, 4'b0100, rd, lat);
        e_load = bmerge(e_load, 32'hAABB_CCDD, 4'b0100);
        xfer(B1 + R_LOAD, 32'd0, 4'd0, rd, lat);
        n_chk++;
        if (rd !== 32'h00BB_0010) begin n_fail++; $display("FAIL load_byte2: got %h, required 00BB0010", rd); end
    endtask

    task automatic test_regs_random();
        logic [31:0] rd, d, expv, o; int lat; logic [3:0] s; int k;
        for (int it = 0; it < 16; it++) begin
            k = int'($urandom_range(5, 0));
            d = $urandom; s = 4'($urandom_range(15, 1));
            case (k)
                0: begin o = R_CTRL; d = d & ~32'h1; if (s[0]) e_ctrl = d[2:0]; end
                1: begin o = R_LOAD;  e_load  = bmerge(e_load, d, s); end
                2: begin o = R_COUNT; e_count = bmerge(e_count, d, s); end
                3: begin o = R_PRE;   e_pre   = bmerge(e_pre, d, s) & 32'hFFFF; end
                4: o = 32'h18 + 32'(4 * $urandom_range(57, 0));
                default: o = R_STAT;
            endcase
            xfer(B1 + o, d, s, rd, lat);
            n_chk++;
            if (lat !== 4) begin n_fail++; $display("FAIL rand_wr_lat off=%h: got %0d, required 4", o, lat); end
            case (k)
                0: expv = {29'd0, e_ctrl};
                1: expv = e_load;
                2: expv = e_count;
                3: expv = e_pre;
                default: expv = 32'd0;
            endcase
            xfer(B1 + o, 32'd0, 4'd0, rd, lat);
            n_chk++;
            if (rd !== expv) begin n_fail++; $display("FAIL rand_rd off=%h: got %h, required %h", o, rd, expv); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; bit seen;
        seen = 0;
        addr = B1 + R_LOAD; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; seen |= ready; end
        valid = 1'b0; wstrb = '0;
        repeat (6) begin @(posedge clk); #1; seen |= ready; end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL abort_ready: got ready 1, required 0"); end
        xfer(B1 + R_LOAD, 32'd0, 4'd0, rd, lat);
        n_chk++;
        if (rd !== e_load) begin n_fail++; $display("FAIL abort_load: got %h, required %h", rd, e_load); end
    endtask

    task automatic test_window();
        logic [31:0] rd; int lat; bit bad;
        bad = 0;
        addr = 32'h0400_0000; wdata = 32'hFFFF_FFFF; wstrb = 4'd0; valid = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (ready !== 1'b0 || rdata !== 32'd0) bad = 1; end
        valid = 1'b0;
        n_chk++;
        if (bad) begin n_fail++; $display("FAIL outside_window: got ready/rdata activity, required none"); end
        xfer(B0 + 32'h20, 32'hFFFF_FFFF, 4'hF, rd, lat);
        xfer(B0 + 32'h20, 32'd0, 4'd0, rd, lat);
        n_chk++;
        if (rd !== 32'd0 || lat !== 1) begin
            n_fail++; $display("FAIL unmapped_0x20: got %h lat %0d, required 0 lat 1", rd, lat);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd; int lat; int unsigned p, c, k, got, expv;
        for (int it = 0; it < 5; it++) begin
            p = (it == 0) ? 0 : $urandom_range(3, 0);
            c = (it == 0) ? 0 : $urandom_range(6, 0);
            xfer(B0 + R_CTRL, 32'd0, 4'hF, rd, lat);
            xfer(B0 + R_STAT, 32'd1, 4'h1, rd, lat);
            xfer(B0 + R_PRE, p, 4'hF, rd, lat);
            xfer(B0 + R_COUNT, c, 4'hF, rd, lat);
            n_chk++;
            if (irq0 !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_idle: got %b, required 0", irq0); end
            xfer(B0 + R_CTRL, 32'h5, 4'h1, rd, lat);
            k = last_ack;
            while (irq0 !== 1'b1 && (cyc - (k + 1)) < 200) begin @(posedge clk); #1; end
            got = cyc - (k + 1);
            // c+1 ticks of p+1 cycles, one cycle to flag expiry, one more for irq
            expv = (c + 1) * (p + 1) + 1;
            n_chk++;
            if (got !== expv) begin n_fail++; $display("FAIL oneshot_irq_time p=%0d c=%0d: got %0d, required %0d", p, c, got, expv); end
            xfer(B0 + R_CTRL, 32'd0, 4'd0, rd, lat);
            n_chk++;
            if (rd !== 32'h4) begin n_fail++; $display("FAIL oneshot_ctrl: got %h, required 4", rd); end
            xfer(B0 + R_COUNT, 32'd0, 4'd0, rd, lat);
            n_chk++;
            if (rd !== 32'd0) begin n_fail++; $display("FAIL oneshot_count: got %h, required 0", rd); end
            xfer(B0 + R_STAT, 32'd0, 4'd0, rd, lat);
            n_chk++;
            if (rd !== 32'd1) begin n_fail++; $display("FAIL oneshot_status: got %h, required 1", rd); end
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] rd, cm; int lat; int unsigned k, m, got, ticks;
        xfer(B0 + R_CTRL, 32'd0, 4'hF, rd, lat);
        xfer(B0 + R_STAT, 32'd1, 4'h1, rd, lat);
        xfer(B0 + R_PRE, 32'd1, 4'hF, rd, lat);
        xfer(B0 + R_LOAD, 32'd2, 4'hF, rd, lat);
        xfer(B0 + R_COUNT, 32'd2, 4'hF, rd, lat);
        xfer(B0 + R_CTRL, 32'h7, 4'h1, rd, lat);
        k = last_ack;
        while (irq0 !== 1'b1 && (cyc - (k + 1)) < 200) begin @(posedge clk); #1; end
        got = cyc - (k + 1);
        n_chk++;
        if (got !== 7) begin n_fail++; $display("FAIL reload_irq_time: got %0d, required 7", got); end
        xfer(B0 + R_CTRL, 32'h6, 4'h1, rd, lat);
        m = last_ack;
        ticks = (m - k) / 2;
        cm = 32'd2;
        repeat (ticks) cm = (cm == 0) ? 32'd2 : cm - 1;
        xfer(B0 + R_COUNT, 32'd0, 4'd0, rd, lat);
        n_chk++;
        if (rd !== cm) begin n_fail++; $display("FAIL reload_count ticks=%0d: got %h, required %h", ticks, rd, cm); end
        xfer(B0 + R_STAT, 32'd1, 4'h1, rd, lat);
        n_chk++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_lag: got %b, required 1", irq0); end
        @(posedge clk); #1;
        n_chk++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_drop: got %b, required 0", irq0); end
        xfer(B0 + R_STAT, 32'd0, 4'd0, rd, lat);
        n_chk++;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL w1c_status: got %h, required 0", rd); end
    endtask

    task automatic test_capture();
        logic [31:0] rd, expv; int lat;
`ifdef IOMEM_TIMER_CAPTURE_EN
        int unsigned k, q;
        xfer(B0 + R_CTRL, 32'd0, 4'hF, rd, lat);
        xfer(B0 + R_PRE, 32'd0, 4'hF, rd, lat);
        xfer(B0 + R_COUNT, 32'd1000, 4'hF, rd, lat);
        xfer(B0 + R_CTRL, 32'h1, 4'h1, rd, lat);
        k = last_ack;
        repeat (3) @(posedge clk);
        #1 cap = 1'b1; q = cyc;
        expv = 32'd1000 - (q + 2 - (k + 1));
        repeat (5) @(posedge clk);
        #1 cap = 1'b0;
        xfer(B0 + R_CTRL, 32'd0, 4'hF, rd, lat);
`else
        expv = 32'd0;
        cap = 1'b1;
        repeat (4) @(posedge clk);
        #1 cap = 1'b0;
`endif
        xfer(B0 + R_CAP, 32'd0, 4'd0, rd, lat);
        n_chk++;
        if (rd !== expv) begin n_fail++; $display("FAIL capture_reg: got %h, required %h", rd, expv); end
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_wstrb();
        test_regs_random();
        test_abort();
        test_window();
        test_oneshot();
        test_autoreload();
        test_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
